btn_conditioner: RTL
====================

# btn_conditioner

Conditions raw push-button inputs for the rest of the board logic. Each of N buttons is synchronised to `clk`, debounced by a stable-count filter, and turned into a clean level plus one-cycle `press`/`release` pulses. An optional hold-to-repeat generator adds `press` pulses while a button is held. The block sits directly downstream of the board pins and feeds counter and display-control logic, which consume only single-cycle pulses.

## Interface
- `N`, 5: number of buttons.
- `DB_CYCLES`, 100000: consecutive stable cycles needed to accept a change (10 ms at 10 MHz). Must be ≥ 2.
- `REPEAT_DELAY`, 5000000: cycles from the initial `press` to the first repeat pulse. Must be ≥ 2.
- `REPEAT_RATE`, 1000000: cycles between later repeat pulses. Must be ≥ 1.
- `clk`, in, 1: the single clock, 10 MHz system clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `btn_in`, in, N: raw asynchronous button pins, high = pressed.
- `level`, out, N: debounced button state.
- `press`, out, N: one-cycle pulse on an accepted press, and on each repeat.
- `release`, out, N: one-cycle pulse on an accepted release.

## Operation
- Every bit is independent and handled by an identical channel.
- Synchroniser: two flops, `s1 <= btn_in`, then `s2 <= s1`. Only `s2` is used downstream.
- Debounce: a counter of width `$clog2(DB_CYCLES)`.
  - `s2 == level`: counter cleared to 0.
  - `s2 != level` and counter < `DB_CYCLES-1`: counter increments.
  - `s2 != level` and counter == `DB_CYCLES-1`: `level <= s2` and counter cleared.
  - Any bounce back to the old value during the window clears the counter, so the window restarts.
- Edge pulses: all outputs are registered and update on the same edge.
  - `press` is high for exactly the one cycle after `level` goes 0→1.
  - `release` is high for exactly the one cycle after `level` goes 1→0.
  - `press` and `release` are never both high on the same bit.
- Reset: every flop clears asynchronously; `level`, `press`, `release` = 0.
  - A button held through reset is treated as a new press once it has been stable for `DB_CYCLES` after reset.
  - No `release` pulse is emitted because of reset.
- Repeat state per channel (only with the repeat feature compiled in):
  - IDLE: `level` = 0.
  - DELAY: entered when `level` rises. The counter runs up to `REPEAT_DELAY`, then emits `press` and moves to REPEAT.
  - REPEAT: emits `press` every `REPEAT_RATE` cycles.
  - `level` falling returns the channel to IDLE from any state, with the counter cleared. A release on the same edge as a repeat expiry wins: `release` pulses and `press` does not.

## Timing
- Raw change sampled at edge 0: `s2` reflects it after edge 1, and `level` changes at edge `DB_CYCLES+1`.
- The `press`/`release` pulse is high during the cycle after edge `DB_CYCLES+1`.
- Total pin-to-pulse latency is `DB_CYCLES+2` cycles.
- Repeat pulses go high `REPEAT_DELAY` cycles after the initial `press` cycle, then every `REPEAT_RATE` cycles after that.
- Pulse width is always exactly 1 cycle. Counters never wrap: they saturate or clear as specified above.

## Configuration
- Macro: `BTN_CONDITIONER_REPEAT_EN`.
- Defined: the repeat state machine and its counter of width `$clog2(max(REPEAT_DELAY, REPEAT_RATE)+1)` are built. `press` carries the initial press pulse plus repeat pulses.
- Undefined: no repeat logic is built and `REPEAT_*` are ignored. `press` pulses exactly once per accepted press.

## Structure
- Shared package `btn_cond_pkg` holds:
  - the default constants `DB_CYCLES_10MHZ`, `REPEAT_DELAY_10MHZ`, `REPEAT_RATE_10MHZ`;
  - the repeat state encoding IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2.
- Sub-module `btn_channel` implements one bit: synchroniser, debounce, edge pulses and repeat. The top instantiates N copies in a generate loop.

## Test plan
All cases use `DB_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_RATE`=3, N=2.
- Reset held with `btn_in`=2'b11, then released: outputs stay 0 during reset. After reset, `level`=2'b11 and a `press` of 2'b11 appear 6 cycles after the first post-reset edge, and no `release` pulse occurs.
- Clean press on bit 0 sampled at edge 0: `level[0]` rises at edge 5 and `press[0]` is high for the single cycle after edge 5.
- Bounce: bit 0 goes high for 3 cycles, low for 1, then high steadily. There is no `press` until 4 stable cycles after the final rise, and exactly one `press` pulse occurs.
- Release after a 6-cycle hold: `release[0]` pulses once, 6 cycles after the pin falls, and `press[0]` is low throughout.
- Repeat (macro defined), bit 1 held for 30 cycles after `level` rises: `press[1]` pulses at relative cycles 0, 10, 13, 16, 19, 22, 25, 28.
- The same hold with the macro undefined gives exactly one `press[1]` pulse. A release coinciding with a repeat expiry gives a `release` pulse and no `press`.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// rtl/btn_cond_pkg.sv - shared constants and repeat-state encoding for btn_conditioner
package btn_cond_pkg;

    // 10 MHz defaults: 10 ms debounce, 0.5 s to first repeat, 0.1 s between repeats
    localparam int DB_CYCLES_10MHZ    = 100000;
    localparam int REPEAT_DELAY_10MHZ = 5000000;
    localparam int REPEAT_RATE_10MHZ  = 1000000;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchroniser, debounce, edge pulses, optional repeat (BTN_CONDITIONER_REPEAT_EN)
module btn_channel
    import btn_cond_pkg::*;
#(
    parameter int DB_CYCLES    = DB_CYCLES_10MHZ,
    parameter int REPEAT_DELAY = REPEAT_DELAY_10MHZ,
    parameter int REPEAT_RATE  = REPEAT_RATE_10MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press,
    output logic released
);

    localparam int DBW = $clog2(DB_CYCLES);

    logic           s1;
    logic           s2;
    logic [DBW-1:0] db_cnt;
    logic           accept;
    logic           rise;
    logic           fall;

    // The debounced level flips on the edge where the window of disagreement completes
    assign accept = (s2 != level) && (db_cnt == DBW'(DB_CYCLES - 1));
    assign rise   = accept && s2;
    assign fall   = accept && !s2;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Stable-count filter: any agreement with the current level restarts the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (s2 == level) begin
            db_cnt <= '0;
        end else if (accept) begin
            db_cnt <= '0;
            level  <= s2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

`ifdef BTN_CONDITIONER_REPEAT_EN
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

    rpt_state_t    state;
    logic [RW-1:0] rpt_cnt;

    // Edge pulses plus hold-to-repeat; a falling level overrides any repeat expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RPT_IDLE;
            rpt_cnt  <= '0;
            press    <= 1'b0;
            released <= 1'b0;
        end else if (fall) begin
            state    <= RPT_IDLE;
            rpt_cnt  <= '0;
            press    <= 1'b0;
            released <= 1'b1;
        end else if (rise) begin
            state    <= RPT_DELAY;
            rpt_cnt  <= '0;
            press    <= 1'b1;
            released <= 1'b0;
        end else begin
            press    <= 1'b0;
            released <= 1'b0;
            case (state)
                RPT_DELAY: begin
                    if (rpt_cnt == RW'(REPEAT_DELAY - 1)) begin
                        press   <= 1'b1;
                        rpt_cnt <= '0;
                        state   <= RPT_REPEAT;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (rpt_cnt == RW'(REPEAT_RATE - 1)) begin
                        press   <= 1'b1;
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    rpt_cnt <= '0;
                end
            endcase
        end
    end
`else
    // Edge pulses registered alongside the level change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            press    <= rise;
            released <= fall;
        end
    end
`endif

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N independent button channels; repeat built with BTN_CONDITIONER_REPEAT_EN
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int N            = 5,
    parameter int DB_CYCLES    = DB_CYCLES_10MHZ,
    parameter int REPEAT_DELAY = REPEAT_DELAY_10MHZ,
    parameter int REPEAT_RATE  = REPEAT_RATE_10MHZ
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] released
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES   (DB_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .btn     (btn_in[i]),
            .level   (level[i]),
            .press   (press[i]),
            .released(released[i])
        );
    end

endmodule
